// File: rtl/uart_tx_fifo.sv
// UART transmitter with configurable data width, parity and stop bits, fed by a transmit FIFO.
// Defining UART_TX_FIFO_BREAK_EN adds the i_Break input for line-break generation.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                        i_Clock,
    input  logic                        i_Rst,
    input  logic                        i_TX_DV,
    input  logic [DATA_BITS-1:0]        i_TX_Data,
`ifdef UART_TX_FIFO_BREAK_EN
    input  logic                        i_Break,
`endif
    output logic                        o_TX_Ready,
    output logic                        o_TX_Overflow,
    output logic [$clog2(FIFO_DEPTH):0] o_FIFO_Count,
    output logic                        o_TX_Active,
    output logic                        o_TX_Serial,
    output logic                        o_TX_Done
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] DATA_LAST = IW'(DATA_BITS - 1);
    localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);
    localparam logic [CW-1:0] DEPTH     = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
`ifdef UART_TX_FIFO_BREAK_EN
        , S_BREAK,
        S_MARK
`endif
    } state_t;

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]        count_q;
    state_t               state_q;
    logic [TW-1:0]        tick_q;
    logic [IW-1:0]        bit_idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 parity_q, serial_q, active_q, done_q, overflow_q;

    logic                 full, push, pop, bit_end, stop_end, line_d;
    logic [DATA_BITS-1:0] head;

    // NOTE: combinational logic uses blocking '=' with a default first, so no latch is inferred.
    always_comb begin
        full     = (count_q == DEPTH);
        push     = i_TX_DV && !full;
        bit_end  = (tick_q == '0);
        stop_end = (state_q == S_STOP) && bit_end && (bit_idx_q == STOP_LAST);
        head     = mem_q[rd_ptr_q];
        pop      = (count_q != '0) && ((state_q == S_IDLE) || stop_end);
`ifdef UART_TX_FIFO_BREAK_EN
        if (i_Break) pop = 1'b0;
`endif
        line_d = 1'b1;
        case (state_q)
            S_START:  line_d = 1'b0;
            S_DATA:   line_d = shift_q[0];
            S_PARITY: line_d = parity_q;
`ifdef UART_TX_FIFO_BREAK_EN
            S_BREAK:  line_d = 1'b0;
`endif
            default:  line_d = 1'b1;
        endcase
    end

    // NOTE: the storage array has no reset; the pointers and count alone decide which entries are valid.
    always_ff @(posedge i_Clock) begin
        if (push) mem_q[wr_ptr_q] <= i_TX_Data;
    end

    always_ff @(posedge i_Clock) begin
        if (i_Rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (pop && !push) count_q <= count_q - 1'b1;
        end
    end

    // Outputs are registered from the current state, so the line trails the FSM by one cycle.
    always_ff @(posedge i_Clock) begin
        if (i_Rst) begin
            state_q    <= S_IDLE;
            tick_q     <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            serial_q   <= 1'b1;
            active_q   <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            serial_q   <= line_d;
            active_q   <= (state_q != S_IDLE);
            done_q     <= stop_end;
            overflow_q <= i_TX_DV && full;

            case (state_q)
                S_START: begin
                    if (bit_end) begin
                        tick_q    <= BIT_LAST;
                        bit_idx_q <= '0;
                        state_q   <= S_DATA;
                    end else tick_q <= tick_q - 1'b1;
                end
                S_DATA: begin
                    if (bit_end) begin
                        tick_q  <= BIT_LAST;
                        shift_q <= shift_q >> 1;
                        if (bit_idx_q == DATA_LAST) begin
                            bit_idx_q <= '0;
                            state_q   <= (PARITY != 0) ? S_PARITY : S_STOP;
                        end else bit_idx_q <= bit_idx_q + 1'b1;
                    end else tick_q <= tick_q - 1'b1;
                end
                S_PARITY: begin
                    if (bit_end) begin
                        tick_q    <= BIT_LAST;
                        bit_idx_q <= '0;
                        state_q   <= S_STOP;
                    end else tick_q <= tick_q - 1'b1;
                end
                S_STOP: begin
                    if (bit_end) begin
                        tick_q <= BIT_LAST;
                        if (bit_idx_q == STOP_LAST) begin
                            bit_idx_q <= '0;
                            state_q   <= S_IDLE;
`ifdef UART_TX_FIFO_BREAK_EN
                            if (i_Break) state_q <= S_BREAK;
`endif
                        end else bit_idx_q <= bit_idx_q + 1'b1;
                    end else tick_q <= tick_q - 1'b1;
                end
`ifdef UART_TX_FIFO_BREAK_EN
                S_IDLE: begin
                    if (i_Break) state_q <= S_BREAK;
                end
                S_BREAK: begin
                    if (!i_Break) begin
                        tick_q  <= BIT_LAST;
                        state_q <= S_MARK;
                    end
                end
                S_MARK: begin
                    if (bit_end) state_q <= S_IDLE;
                    else         tick_q  <= tick_q - 1'b1;
                end
`endif
                default: ;
            endcase

            // NOTE: placed after the case so its non-blocking assignments take precedence.
            if (pop) begin
                shift_q  <= head;
                parity_q <= (^head) ^ (PARITY == 1);
                tick_q   <= BIT_LAST;
                state_q  <= S_START;
            end
        end
    end

    assign o_TX_Ready    = !full;
    assign o_TX_Overflow = overflow_q;
    assign o_FIFO_Count  = count_q;
    assign o_TX_Active   = active_q;
    assign o_TX_Serial   = serial_q;
    assign o_TX_Done     = done_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: vector table, directed frame sequences and a
// randomized run compared against a frame-level reference model.
module tb_uart_tx_fifo;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int LEN_A = (1 + 8 + 0 + 1) * CPB;
    localparam int LEN_B = (1 + 7 + 1 + 2) * CPB;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst    = 1'b1;
    logic       dv_a   = 1'b0;
    logic [7:0] data_a = 8'h00;
    logic       dv_b   = 1'b0;
    logic [6:0] data_b = 7'h00;

    logic       ready_a, ovf_a, active_a, serial_a, done_a;
    logic [2:0] count_a;
    logic       ready_b, ovf_b, active_b, serial_b, done_b;
    logic [2:0] count_b;

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut_a (
        .i_Clock(clk), .i_Rst(rst), .i_TX_DV(dv_a), .i_TX_Data(data_a),
`ifdef UART_TX_FIFO_BREAK_EN
        .i_Break(1'b0),
`endif
        .o_TX_Ready(ready_a), .o_TX_Overflow(ovf_a), .o_FIFO_Count(count_a),
        .o_TX_Active(active_a), .o_TX_Serial(serial_a), .o_TX_Done(done_a)
    );

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) dut_b (
        .i_Clock(clk), .i_Rst(rst), .i_TX_DV(dv_b), .i_TX_Data(data_b),
`ifdef UART_TX_FIFO_BREAK_EN
        .i_Break(1'b0),
`endif
        .o_TX_Ready(ready_b), .o_TX_Overflow(ovf_b), .o_FIFO_Count(count_b),
        .o_TX_Active(active_b), .o_TX_Serial(serial_b), .o_TX_Done(done_b)
    );

    int n_vec = 0;
    int n_miss = 0;
    int cyc = 0;
    int done_cnt_a = 0;

    // Reference model for dut_a: queued words plus cycles left in the frame being sent.
    logic [7:0] mq[$];
    logic [7:0] m_word = 8'h00;
    int         m_left = 0;

    typedef struct {
        logic       rst;
        logic       dv;
        logic [7:0] data;
        int         count;
        logic       ready;
        logic       ovf;
        logic       active;
        logic       serial;
    } vec_t;
    vec_t tbl[8];

    int a5_bits[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Line level of a frame at cycle k, built from start/data/parity/stop rules.
    function automatic logic exp_bit(input logic [8:0] w, input int k, input int cpb,
                                     input int db, input int par);
        int   b;
        logic x;
        b = k / cpb;
        x = 1'b0;
        for (int i = 0; i < db; i++) x = x ^ w[i];
        if (b == 0) return 1'b0;
        if (b <= db) return w[b-1];
        if (par != 0 && b == db + 1) return (par == 1) ? ~x : x;
        return 1'b1;
    endfunction

    task automatic step();
        logic e_ser, e_act, e_done, e_ovf, full;
        @(posedge clk);
        if (rst) begin
            mq.delete();
            m_left = 0;
            e_ser  = 1'b1;
            e_act  = 1'b0;
            e_done = 1'b0;
            e_ovf  = 1'b0;
        end else begin
            e_ser  = (m_left > 0) ? exp_bit({1'b0, m_word}, LEN_A - m_left, CPB, 8, 0) : 1'b1;
            e_act  = (m_left > 0);
            e_done = (m_left == 1);
            full   = (mq.size() == DEPTH);
            e_ovf  = dv_a && full;
            if (mq.size() > 0 && m_left <= 1) begin
                m_word = mq.pop_front();
                m_left = LEN_A;
            end else if (m_left > 0) begin
                m_left--;
            end
            if (dv_a && !full) mq.push_back(data_a);
        end
        #1;
        cyc++;
        if (done_a === 1'b1) done_cnt_a++;
        check("m_serial", 32'(serial_a), 32'(e_ser));
        check("m_active", 32'(active_a), 32'(e_act));
        check("m_done", 32'(done_a), 32'(e_done));
        check("m_overflow", 32'(ovf_a), 32'(e_ovf));
        check("m_count", 32'(count_a), 32'(mq.size()));
        check("m_ready", 32'(ready_a), 32'(mq.size() < DEPTH));
    endtask

    task automatic drain_a(input int budget, input string name);
        int n = 0;
        while (!(active_a === 1'b0 && count_a === 3'd0 && mq.size() == 0 && m_left == 0) && n < budget) begin
            step();
            n++;
        end
        check({name, "_timeout"}, 32'(n < budget), 32'd1);
    endtask

    initial begin
        int d0, n, max_cnt;
        bit seen, gap, high;
        int done_t[$];
        int words_b[2] = '{7'h03, 7'h07};
        int par_exp[2] = '{1, 0};

        // Reset, then six back-to-back writes into a four-deep FIFO.
        tbl[0] = '{1'b1, 1'b0, 8'h00, 0, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[1] = '{1'b0, 1'b1, 8'h10, 1, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[2] = '{1'b0, 1'b1, 8'h11, 1, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[3] = '{1'b0, 1'b1, 8'h12, 2, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 8'h13, 3, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 8'h14, 4, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[6] = '{1'b0, 1'b1, 8'h15, 4, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[7] = '{1'b0, 1'b0, 8'h00, 4, 1'b0, 1'b0, 1'b1, 1'b0};

        d0 = done_cnt_a;
        for (int i = 0; i < 8; i++) begin
            rst    = tbl[i].rst;
            dv_a   = tbl[i].dv;
            data_a = tbl[i].data;
            step();
            check("tbl_count", 32'(count_a), 32'(tbl[i].count));
            check("tbl_ready", 32'(ready_a), 32'(tbl[i].ready));
            check("tbl_overflow", 32'(ovf_a), 32'(tbl[i].ovf));
            check("tbl_active", 32'(active_a), 32'(tbl[i].active));
            check("tbl_serial", 32'(serial_a), 32'(tbl[i].serial));
        end
        dv_a = 1'b0;
        drain_a(400, "t3_drain");
        check("t3_frames", 32'(done_cnt_a - d0), 32'd5);

        // Single 0xA5 frame: two-edge latency, bit pattern, one done pulse in the last cycle.
        d0 = done_cnt_a;
        dv_a = 1'b1; data_a = 8'hA5; step(); dv_a = 1'b0;
        step(); check("t1_lat_n1", 32'(serial_a), 32'd1);
        step(); check("t1_lat_n2", 32'(serial_a), 32'd0);
        for (int k = 0; k < LEN_A; k++) begin
            if (k > 0) step();
            check("t1_bit", 32'(serial_a), 32'(a5_bits[k / CPB]));
            check("t1_done", 32'(done_a), 32'(k == LEN_A - 1));
        end
        step();
        check("t1_active_end", 32'(active_a), 32'd0);
        check("t1_done_once", 32'(done_cnt_a - d0), 32'd1);

        // Four words on consecutive cycles: back-to-back frames, continuous active.
        d0 = done_cnt_a; max_cnt = 0; seen = 0; gap = 0; n = 0;
        for (int i = 0; i < 4; i++) begin
            dv_a = 1'b1; data_a = 8'(i); step();
            if (int'(count_a) > max_cnt) max_cnt = int'(count_a);
        end
        dv_a = 1'b0;
        while (done_cnt_a - d0 < 4 && n < 300) begin
            step();
            n++;
            if (int'(count_a) > max_cnt) max_cnt = int'(count_a);
            if (active_a) seen = 1;
            else if (seen) gap = 1;
            if (done_a) done_t.push_back(cyc);
        end
        check("t2_peak_count", 32'(max_cnt), 32'd3);
        check("t2_done_pulses", 32'(done_t.size()), 32'd4);
        for (int i = 1; i < done_t.size(); i++)
            check("t2_done_spacing", 32'(done_t[i] - done_t[i-1]), 32'(LEN_A));
        check("t2_active_gap", 32'(gap), 32'd0);
        drain_a(100, "t2_drain");

        // Reset mid-DATA with two words queued.
        d0 = done_cnt_a;
        for (int i = 0; i < 3; i++) begin
            dv_a = 1'b1; data_a = 8'h11 * 8'(i + 1); step();
        end
        dv_a = 1'b0;
        repeat (10) step();
        check("t5_pre_count", 32'(count_a), 32'd2);
        check("t5_pre_active", 32'(active_a), 32'd1);
        rst = 1'b1; step(); rst = 1'b0;
        check("t5_line_high", 32'(serial_a), 32'd1);
        check("t5_count_zero", 32'(count_a), 32'd0);
        check("t5_active_low", 32'(active_a), 32'd0);
        high = 1;
        repeat (150) begin
            step();
            if (serial_a !== 1'b1) high = 0;
        end
        check("t5_no_done", 32'(done_cnt_a - d0), 32'd0);
        check("t5_line_idle", 32'(high), 32'd1);

        // 7 data bits, odd parity, two stop bits: 0x03 then 0x07 back to back.
        dv_b = 1'b1; data_b = 7'h03; step();
        data_b = 7'h07; step(); dv_b = 1'b0;
        n = 0;
        while (serial_b !== 1'b0 && n < 10) begin step(); n++; end
        check("t4_start_seen", 32'(n < 10), 32'd1);
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < LEN_B; k++) begin
                if (!(f == 0 && k == 0)) step();
                check("t4_bit", 32'(serial_b), 32'(exp_bit(9'(words_b[f]), k, CPB, 7, 1)));
                check("t4_done", 32'(done_b), 32'(k == LEN_B - 1));
                if (k == 8 * CPB) check("t4_parity", 32'(serial_b), 32'(par_exp[f]));
            end
        end
        step();
        check("t4_active_end", 32'(active_b), 32'd0);
        check("t4_line_idle", 32'(serial_b), 32'd1);

        // Randomized traffic at heavy, moderate and sparse write rates, with rare resets.
        for (int ph = 0; ph < 3; ph++) begin
            int rate;
            rate = (ph == 0) ? 50 : (ph == 1) ? 5 : 1;
            repeat (600) begin
                rst    = ($urandom_range(0, 299) == 0);
                dv_a   = ($urandom_range(0, 99) < rate);
                data_a = 8'($urandom);
                step();
            end
        end
        rst = 1'b0; dv_a = 1'b0;
        drain_a(600, "rand_drain");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
